// File: rtl/next_pc_unit_pkg.sv
// Shared types and constants for the fetch-side next-PC generator.
// FSM state encodings, PC increment and parameter defaults live here.
package next_pc_unit_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    PEND = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam int          CNT_W_DEF        = 16;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/next_pc_unit_pc_target_calc.sv
// Combinational branch / jump / jump-register target calculation and priority mux.
// NEXT_PC_ALIGN_CHECK_EN enables flagging of misaligned jr targets.
module pc_target_calc
  import next_pc_unit_pkg::*;
(
  input  logic [31:0] ctl_pc,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic        j_valid,
  input  logic [25:0] j_target,
  input  logic        jr_valid,
  input  logic [31:0] jr_target,
  output logic [31:0] rtgt,
  output logic        redirect,
  output logic        rtgt_misalign
);

  logic [31:0] base_s;
  logic [31:0] br_tgt_s;
  logic [31:0] j_tgt_s;
  logic        jr_misalign_s;

  assign base_s   = ctl_pc + PC_INC;
  assign br_tgt_s = base_s + {{14{br_offset[15]}}, br_offset, 2'b00};
  assign j_tgt_s  = (base_s & 32'hF000_0000) | {4'b0000, j_target, 2'b00};

`ifdef NEXT_PC_ALIGN_CHECK_EN
  assign jr_misalign_s = |jr_target[1:0];
`else
  assign jr_misalign_s = 1'b0;
`endif

  // jr beats j beats taken branch
  always_comb begin
    rtgt          = 32'h0000_0000;
    redirect      = 1'b0;
    rtgt_misalign = 1'b0;
    if (jr_valid) begin
      rtgt          = word_align(jr_target);
      redirect      = 1'b1;
      rtgt_misalign = jr_misalign_s;
    end else if (j_valid) begin
      rtgt     = j_tgt_s;
      redirect = 1'b1;
    end else if (br_taken) begin
      rtgt     = br_tgt_s;
      redirect = 1'b1;
    end else begin
      rtgt     = 32'h0000_0000;
      redirect = 1'b0;
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC generator: sequential/redirect selection, stall hold, one-deep pending redirect.
// Optional jr misalignment reporting is built when NEXT_PC_ALIGN_CHECK_EN is defined.
module next_pc_unit
  import next_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int          CNT_W        = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      PC,
  output logic [31:0]      nextPC,
  output logic             imem_req,
  input  logic             imem_gnt,
  input  logic             stall,
  input  logic [31:0]      ctl_pc,
  input  logic             br_taken,
  input  logic [15:0]      br_offset,
  input  logic             j_valid,
  input  logic [25:0]      j_target,
  input  logic             jr_valid,
  input  logic [31:0]      jr_target,
  output logic             flush,
  output logic             misalign,
  output logic [CNT_W-1:0] stall_cycles
);

  pc_state_e        state_q, state_d;
  logic [31:0]      pend_q, pend_d;
  logic             pend_mis_q, pend_mis_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] rtgt_s;
  logic        redirect_s;
  logic        rtgt_mis_s;
  logic        adv_s;
  logic [31:0] seq_s;

  pc_target_calc u_tgt (
    .ctl_pc        (ctl_pc),
    .br_taken      (br_taken),
    .br_offset     (br_offset),
    .j_valid       (j_valid),
    .j_target      (j_target),
    .jr_valid      (jr_valid),
    .jr_target     (jr_target),
    .rtgt          (rtgt_s),
    .redirect      (redirect_s),
    .rtgt_misalign (rtgt_mis_s)
  );

  assign adv_s    = imem_gnt & ~stall;
  assign seq_s    = PC + PC_INC;
  assign imem_req = reset_n;

  // next-state, pending redirect capture and combinational PC select
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_mis_d = pend_mis_q;
    nextPC     = PC;
    flush      = 1'b0;
    misalign   = 1'b0;
    if (adv_s || (&cnt_q)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    if (!reset_n) begin
      nextPC = RESET_VECTOR;
    end else begin
      case (state_q)
        RUN, HOLD: begin
          misalign = redirect_s & rtgt_mis_s;
          if (adv_s) begin
            state_d = RUN;
            if (redirect_s) begin
              nextPC = rtgt_s;
              flush  = 1'b1;
            end else begin
              nextPC = seq_s;
            end
          end else if (redirect_s) begin
            pend_d     = rtgt_s;
            pend_mis_d = rtgt_mis_s;
            state_d    = PEND;
          end else begin
            state_d = HOLD;
          end
        end
        // the older captured redirect wins over anything presented now
        PEND: begin
          if (adv_s) begin
            nextPC   = pend_q;
            flush    = 1'b1;
            misalign = pend_mis_q;
            state_d  = RUN;
          end else begin
            state_d = PEND;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // state, pending target and stall counter registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= RUN;
      pend_q     <= 32'h0000_0000;
      pend_mis_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_mis_q <= pend_mis_d;
      cnt_q      <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit (small counter width to reach saturation).
module tb_next_pc_unit;
  import next_pc_unit_pkg::*;

  localparam int TB_CNT_W = 4;
`ifdef NEXT_PC_ALIGN_CHECK_EN
  localparam logic [31:0] EXP_MIS = 32'd1;
`else
  localparam logic [31:0] EXP_MIS = 32'd0;
`endif

  logic                clock;
  logic                reset_n;
  logic [31:0]         PC;
  logic [31:0]         nextPC;
  logic                imem_req;
  logic                imem_gnt;
  logic                stall;
  logic [31:0]         ctl_pc;
  logic                br_taken;
  logic [15:0]         br_offset;
  logic                j_valid;
  logic [25:0]         j_target;
  logic                jr_valid;
  logic [31:0]         jr_target;
  logic                flush;
  logic                misalign;
  logic [TB_CNT_W-1:0] stall_cycles;

  int n_chk;
  int n_fail;

  next_pc_unit #(
    .RESET_VECTOR (32'h0000_0000),
    .CNT_W        (TB_CNT_W)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .PC           (PC),
    .nextPC       (nextPC),
    .imem_req     (imem_req),
    .imem_gnt     (imem_gnt),
    .stall        (stall),
    .ctl_pc       (ctl_pc),
    .br_taken     (br_taken),
    .br_offset    (br_offset),
    .j_valid      (j_valid),
    .j_target     (j_target),
    .jr_valid     (jr_valid),
    .jr_target    (jr_target),
    .flush        (flush),
    .misalign     (misalign),
    .stall_cycles (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt32();
    return {{(32-TB_CNT_W){1'b0}}, stall_cycles};
  endfunction

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    PC        = 32'h0;
    imem_gnt  = 1'b0;
    stall     = 1'b0;
    ctl_pc    = 32'h0;
    br_taken  = 1'b0;
    br_offset = 16'h0;
    j_valid   = 1'b0;
    j_target  = 26'h0;
    jr_valid  = 1'b0;
    jr_target = 32'h0;

    // reset
    @(negedge clock); #1;
    chk("rst_npc", nextPC, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_mis", {31'd0, misalign}, 32'd0);
    @(negedge clock);
    chk("rst_cnt", cnt32(), 32'd0);

    // sequential fetch
    reset_n = 1'b1; imem_gnt = 1'b1; PC = 32'h0; #1;
    chk("seq0", nextPC, 32'd4);
    chk("seq_req", {31'd0, imem_req}, 32'd1);
    chk("seq_flush", {31'd0, flush}, 32'd0);
    @(negedge clock); PC = 32'd4; #1; chk("seq1", nextPC, 32'd8);
    @(negedge clock); PC = 32'd8; #1; chk("seq2", nextPC, 32'd12);
    chk("seq_cnt", cnt32(), 32'd0);

    // backward branch, then flush drops
    @(negedge clock);
    PC = 32'h100; ctl_pc = 32'h0FC; br_taken = 1'b1; br_offset = 16'hFFFF; #1;
    chk("br_npc", nextPC, 32'h0FC);
    chk("br_flush", {31'd0, flush}, 32'd1);
    @(negedge clock); br_taken = 1'b0; PC = 32'h0FC; #1;
    chk("br_after_npc", nextPC, 32'h100);
    chk("br_after_flush", {31'd0, flush}, 32'd0);

    // j beats branch; branch alone
    @(negedge clock);
    PC = 32'h200; ctl_pc = 32'h1FC; br_taken = 1'b1; br_offset = 16'h0010;
    j_valid = 1'b1; j_target = 26'h123; #1;
    chk("prio_j", nextPC, 32'h48C);
    @(negedge clock); j_valid = 1'b0; #1;
    chk("br_fwd", nextPC, 32'h240);
    @(negedge clock); br_taken = 1'b0;

    // redirect during 3-cycle stall goes pending; later jr ignored
    PC = 32'h0F8; ctl_pc = 32'h0FC; stall = 1'b1; j_valid = 1'b1; j_target = 26'h40; #1;
    chk("st1_npc", nextPC, 32'h0F8);
    chk("st1_flush", {31'd0, flush}, 32'd0);
    @(negedge clock); j_valid = 1'b0; jr_valid = 1'b1; jr_target = 32'h2000; #1;
    chk("st2_npc", nextPC, 32'h0F8);
    chk("st2_flush", {31'd0, flush}, 32'd0);
    @(negedge clock); #1;
    chk("st3_npc", nextPC, 32'h0F8);
    @(negedge clock); stall = 1'b0; #1;
    chk("pend_npc", nextPC, 32'h100);
    chk("pend_flush", {31'd0, flush}, 32'd1);
    chk("pend_cnt", cnt32(), 32'd3);
    @(negedge clock); jr_valid = 1'b0; PC = 32'h100; #1;
    chk("post_pend_npc", nextPC, 32'h104);
    chk("post_pend_flush", {31'd0, flush}, 32'd0);

    // no grant -> HOLD, then resume
    @(negedge clock); imem_gnt = 1'b0; PC = 32'h104; #1;
    chk("hold_npc", nextPC, 32'h104);
    chk("hold_flush", {31'd0, flush}, 32'd0);
    @(negedge clock); imem_gnt = 1'b1; #1;
    chk("hold_rel_npc", nextPC, 32'h108);
    chk("hold_cnt", cnt32(), 32'd4);

    // wrap
    @(negedge clock); PC = 32'hFFFF_FFFC; #1;
    chk("wrap_npc", nextPC, 32'h0);

    // jr alignment
    @(negedge clock); PC = 32'h300; jr_valid = 1'b1; jr_target = 32'h1003; #1;
    chk("jr_mis_npc", nextPC, 32'h1000);
    chk("jr_mis_flag", {31'd0, misalign}, EXP_MIS);
    @(negedge clock); jr_target = 32'h1004; j_valid = 1'b1; j_target = 26'h5; #1;
    chk("jr_prio_npc", nextPC, 32'h1004);
    chk("jr_ok_flag", {31'd0, misalign}, 32'd0);
    @(negedge clock); j_valid = 1'b0; stall = 1'b1; jr_target = 32'h1003; #1;
    chk("jr_st_npc", nextPC, 32'h300);
    @(negedge clock); stall = 1'b0; jr_valid = 1'b0; #1;
    chk("jr_pend_npc", nextPC, 32'h1000);
    chk("jr_pend_flush", {31'd0, flush}, 32'd1);
    chk("jr_pend_mis", {31'd0, misalign}, EXP_MIS);

    // reset while PEND discards the pending target
    @(negedge clock); stall = 1'b1; ctl_pc = 32'h0FC; j_valid = 1'b1; j_target = 26'h40;
    @(negedge clock); reset_n = 1'b0; stall = 1'b0; j_valid = 1'b0; #1;
    chk("rpend_npc", nextPC, 32'h0);
    chk("rpend_req", {31'd0, imem_req}, 32'd0);
    @(negedge clock); reset_n = 1'b1; PC = 32'h0; #1;
    chk("rpend_first", nextPC, 32'd4);
    chk("rpend_flush", {31'd0, flush}, 32'd0);
    chk("rpend_cnt", cnt32(), 32'd0);

    // counter saturation
    stall = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge clock);
    stall = 1'b0; #1;
    chk("sat_cnt", cnt32(), 32'd15);
    @(negedge clock); stall = 1'b1;
    @(negedge clock); #1;
    chk("sat_hold", cnt32(), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
